txpyfetch: RTL

TXPYFETCH -- requirements
Module: txpyfetch

---
 rtl/txpy_pkg.sv | 28 ++
 rtl/txpyword_reg.sv | 51 +++++
 rtl/txpyfetch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/txpy_pkg.sv
// ============================================================
// Package : txpy_pkg
// Shared widths, FSM encoding and word-count helper for txpyfetch.
// Revision: 1.0
// ============================================================
`default_nettype none

package txpy_pkg;

    localparam int c_WORD_W = 32;
    localparam int c_ADDR_W = 8;
    localparam int c_BCNT_W = 13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } txpy_state_t;

    // ceil(len/32) in 9 bits, so 8191 bits -> 256 words without overflow
    function automatic logic [c_ADDR_W:0] nwords_f(input logic [c_BCNT_W-1:0] len);
        nwords_f = {1'b0, len[c_BCNT_W-1:5]} + {{c_ADDR_W{1'b0}}, |len[4:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/txpyword_reg.sv
// ============================================================
// Module : txpyword_reg
// One payload word slot: data, tag and valid with tag comparators.
// Revision: 1.0
// ============================================================
`default_nettype none

module txpyword_reg
    import txpy_pkg::*;
(
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                i_clr,
    input  logic                i_rel,
    input  logic                i_wr,
    input  logic [c_ADDR_W-1:0] i_tag,
    input  logic [c_ADDR_W-1:0] i_widx,
    input  logic [c_WORD_W-1:0] i_data,
    output logic                o_valid,
    output logic                o_match,
    output logic                o_older,
    output logic [c_WORD_W-1:0] o_data
);

    logic                r_valid;
    logic [c_ADDR_W-1:0] r_tag;
    logic [c_WORD_W-1:0] r_data;

    // A write into a slot being released in the same cycle wins
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_data  <= i_data;
        end else if (i_clr || i_rel) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_match = r_valid && (r_tag == i_widx);
    assign o_older = r_valid && (r_tag <  i_widx);

endmodule

`default_nettype wire

// File: rtl/txpyfetch.sv
// ============================================================
// Module : txpyfetch
// Double-buffered TX payload fetch from SRAM with bit serialisation.
// Option : TXPYFETCH_UNDERRUN_EN enables sticky underrun detection.
// Revision: 1.0
// ============================================================
`default_nettype none

module txpyfetch
    import txpy_pkg::*;
(
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                py_st_p,
    input  logic                py_period,
    input  logic [12:0]         pybitcount,
    input  logic [12:0]         pylenbit,
    output logic                mem_req,
    output logic [c_ADDR_W-1:0] mem_adr,
    input  logic                mem_rack,
    input  logic [c_WORD_W-1:0] mem_rdata,
    output logic                bufpacketin,
    output logic [c_WORD_W-1:0] lnctrl_bufpacket,
    output logic                latchpyhead_p,
    output logic                underrun
);

    txpy_state_t         r_state;
    txpy_state_t         w_state_nxt;
    logic [c_ADDR_W:0]   r_nadr;
    logic                r_period_d;

    logic [c_ADDR_W-1:0] w_widx;
    logic [4:0]          w_bsel;
    logic [c_ADDR_W:0]   w_nwords;
    logic                w_pyfall;
    logic                w_clr;
    logic                w_ack;
    logic                w_rel_a, w_rel_b;
    logic                w_a_free;
    logic                w_wr_a, w_wr_b;
    logic                w_both_nxt;

    logic                w_a_valid, w_a_match, w_a_older;
    logic                w_b_valid, w_b_match, w_b_older;
    logic [c_WORD_W-1:0] w_a_data, w_b_data;

    assign w_widx   = pybitcount[12:5];
    assign w_bsel   = pybitcount[4:0];
    assign w_nwords = nwords_f(pylenbit);
    assign w_pyfall = r_period_d && !py_period;
    assign w_clr    = py_st_p || w_pyfall;

    // Acks landing in a restart or window-close cycle are dropped
    assign w_ack    = (r_state == S_WAIT) && mem_rack && !w_clr;
    assign w_rel_a  = py_period && w_a_older;
    assign w_rel_b  = py_period && w_b_older;

    // Release is applied before choosing the write target
    assign w_a_free   = !w_a_valid || w_rel_a;
    assign w_wr_a     = w_ack && w_a_free;
    assign w_wr_b     = w_ack && !w_a_free;
    assign w_both_nxt = ((w_a_valid && !w_rel_a) || w_wr_a) &&
                        ((w_b_valid && !w_rel_b) || w_wr_b);

    txpyword_reg u_slot_a (
        .clk_6M  (clk_6M),
        .rstz    (rstz),
        .i_clr   (w_clr),
        .i_rel   (w_rel_a),
        .i_wr    (w_wr_a),
        .i_tag   (r_nadr[c_ADDR_W-1:0]),
        .i_widx  (w_widx),
        .i_data  (mem_rdata),
        .o_valid (w_a_valid),
        .o_match (w_a_match),
        .o_older (w_a_older),
        .o_data  (w_a_data)
    );

    txpyword_reg u_slot_b (
        .clk_6M  (clk_6M),
        .rstz    (rstz),
        .i_clr   (w_clr),
        .i_rel   (w_rel_b),
        .i_wr    (w_wr_b),
        .i_tag   (r_nadr[c_ADDR_W-1:0]),
        .i_widx  (w_widx),
        .i_data  (mem_rdata),
        .o_valid (w_b_valid),
        .o_match (w_b_match),
        .o_older (w_b_older),
        .o_data  (w_b_data)
    );

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state          <= S_IDLE;
            r_nadr           <= '0;
            r_period_d       <= 1'b0;
            lnctrl_bufpacket <= '0;
            latchpyhead_p    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_period_d    <= py_period;
            latchpyhead_p <= w_ack && (r_nadr == '0);
            if (py_st_p)
                r_nadr <= '0;
            else if (w_ack)
                r_nadr <= r_nadr + 1'b1;
            if (w_ack && (r_nadr == '0))
                lnctrl_bufpacket <= mem_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_ack) begin
                    if ((r_nadr + 1'b1) == w_nwords)
                        w_state_nxt = S_IDLE;
                    else if (w_both_nxt)
                        w_state_nxt = S_FULL;
                    else
                        w_state_nxt = S_REQ;
                end
            end
            S_FULL: begin
                if ((w_rel_a || w_rel_b) && (r_nadr < w_nwords))
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = r_state;
        endcase
        if (w_pyfall)
            w_state_nxt = S_IDLE;
        if (py_st_p)
            w_state_nxt = (|pylenbit) ? S_REQ : S_IDLE;
    end

    assign mem_req     = (r_state == S_REQ) || (r_state == S_WAIT);
    assign mem_adr     = r_nadr[c_ADDR_W-1:0];
    assign bufpacketin = w_a_match ? w_a_data[w_bsel] :
                         w_b_match ? w_b_data[w_bsel] : 1'b0;

`ifdef TXPYFETCH_UNDERRUN_EN
    logic r_underrun;
    logic w_match;

    assign w_match = w_a_match || w_b_match;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz)
            r_underrun <= 1'b0;
        else if (py_st_p)
            r_underrun <= 1'b0;
        else if (py_period && ({1'b0, w_widx} < w_nwords) && !w_match)
            r_underrun <= 1'b1;
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

endmodule

`default_nettype wire
